// File: rtl/itlb_ctrl.sv
// Instruction TLB (fully associative, round-robin refill) plus miss FSM for the fetch stage.
// Latency: lookup is combinational (0 cycles); a miss reports MISS_LATENCY+1 cycles after detection.
// Backpressure: itlb_stall freezes fetch during detection and WALK; released for REPORT and refill wait.
module itlb_ctrl #(
    parameter int ENTRIES      = 4,
    parameter int PAGE_BITS    = 12,
    parameter int MISS_LATENCY = 3
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic [31:0]            va,
    input  logic                   abort,
    output logic [31:0]            pa,
    output logic                   hit,
    output logic                   itlb_stall,
    output logic                   itlb_miss,
    output logic                   itlb_ready,
    output logic [31:0]            faulty_va,
    input  logic                   tlb_we,
    input  logic [31-PAGE_BITS:0]  tlb_vpn,
    input  logic [31-PAGE_BITS:0]  tlb_ppn,
    input  logic                   tlb_flush
);

    localparam int VPN_W = 32 - PAGE_BITS;
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        REPORT,
        WAIT_REFILL
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        miss_va_q;
    logic [31:0]        faulty_va_q;
    logic               miss_q;
    logic               ready_q;

    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [VPN_W-1:0]   ppn_q [ENTRIES];
    logic [IDX_W-1:0]   ptr_q;

    logic               lk_match;
    logic [VPN_W-1:0]   lk_ppn;
    logic               rf_match;
    logic [IDX_W-1:0]   rf_idx;
    logic               miss_start;

    // Refill never creates a duplicate VPN, so the match vector is one-hot and OR-reduction is safe.
    always_comb begin
        lk_match = 1'b0;
        lk_ppn   = '0;
        rf_match = 1'b0;
        rf_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == va[31:PAGE_BITS])) begin
                lk_match = 1'b1;
                lk_ppn   = lk_ppn | ppn_q[i];
            end
            if (valid_q[i] && (vpn_q[i] == tlb_vpn)) begin
                rf_match = 1'b1;
                rf_idx   = IDX_W'(i);
            end
        end
    end

    assign hit        = req & lk_match;
    assign pa         = hit ? {lk_ppn, va[PAGE_BITS-1:0]} : 32'h0;
    assign miss_start = (state_q == IDLE) & req & ~lk_match & ~abort;
    assign itlb_stall = (state_q == WALK) | (miss_start & rst_n);
    assign itlb_miss  = miss_q;
    assign itlb_ready = ready_q;
    assign faulty_va  = faulty_va_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (tlb_flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (tlb_we && !rf_match) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (tlb_we && !tlb_flush) begin
            if (rf_match) begin
                ppn_q[rf_idx] <= tlb_ppn;
            end else begin
                vpn_q[ptr_q] <= tlb_vpn;
                ppn_q[ptr_q] <= tlb_ppn;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_va_q   <= '0;
            faulty_va_q <= '0;
            miss_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        state_q   <= WALK;
                        miss_va_q <= va;
                        cnt_q     <= CNT_W'(MISS_LATENCY - 1);
                    end
                end
                WALK: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q     <= REPORT;
                        miss_q      <= 1'b1;
                        ready_q     <= 1'b1;
                        faulty_va_q <= miss_va_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                // The exception is already committed downstream, so abort cannot cancel it here.
                REPORT: begin
                    state_q <= WAIT_REFILL;
                    ready_q <= 1'b0;
                end
                WAIT_REFILL: begin
                    if (tlb_we) begin
                        state_q     <= IDLE;
                        miss_q      <= 1'b0;
                        faulty_va_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    miss_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itlb_ctrl.sv
// Scoreboard bench for itlb_ctrl: lookups and miss reports are queued as driven and checked on output.
module tb_itlb_ctrl;

    localparam int ML = 3;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] va;
    logic        abort;
    logic [31:0] pa;
    logic        hit;
    logic        itlb_stall;
    logic        itlb_miss;
    logic        itlb_ready;
    logic [31:0] faulty_va;
    logic        tlb_we;
    logic [19:0] tlb_vpn;
    logic [19:0] tlb_ppn;
    logic        tlb_flush;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        hit;
        logic [31:0] pa;
    } look_t;

    look_t       look_q[$];
    logic [31:0] miss_q[$];

    always #5 clock = ~clock;

    itlb_ctrl #(.ENTRIES(4), .PAGE_BITS(12), .MISS_LATENCY(ML)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .req        (req),
        .va         (va),
        .abort      (abort),
        .pa         (pa),
        .hit        (hit),
        .itlb_stall (itlb_stall),
        .itlb_miss  (itlb_miss),
        .itlb_ready (itlb_ready),
        .faulty_va  (faulty_va),
        .tlb_we     (tlb_we),
        .tlb_vpn    (tlb_vpn),
        .tlb_ppn    (tlb_ppn),
        .tlb_flush  (tlb_flush)
    );

    task automatic sync;
        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input logic [31:0] v, input logic exp_hit, input logic [31:0] exp_pa);
        look_t e;
        req   = 1'b1;
        abort = ~exp_hit;
        va    = v;
        e.hit = exp_hit;
        e.pa  = exp_pa;
        look_q.push_back(e);
        #2;
        e = look_q.pop_front();
        tests++;
        if (hit !== e.hit || pa !== e.pa) begin
            fails++;
            $display("FAIL lookup va=%h: hit=%b pa=%h, expected hit=%b pa=%h", v, hit, pa, e.hit, e.pa);
        end
        sync;
        req   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic refill(input logic [19:0] vpn, input logic [19:0] ppn, input logic fl);
        tlb_we    = 1'b1;
        tlb_flush = fl;
        tlb_vpn   = vpn;
        tlb_ppn   = ppn;
        sync;
        tlb_we    = 1'b0;
        tlb_flush = 1'b0;
    endtask

    task automatic miss_report(input logic [31:0] v, input logic ab_in_report);
        int          n;
        bit          got;
        logic [31:0] exp_va;
        req   = 1'b1;
        va    = v;
        abort = 1'b0;
        miss_q.push_back(v);
        #2;
        tests++;
        if (hit !== 1'b0 || itlb_stall !== 1'b1) begin
            fails++;
            $display("FAIL miss_detect va=%h: hit=%b stall=%b, expected hit=0 stall=1", v, hit, itlb_stall);
        end
        sync;
        req = 1'b0;
        n   = 0;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            abort = ab_in_report && (n == ML);
            #2;
            if (itlb_ready === 1'b1) begin
                got = 1;
                break;
            end
            if (itlb_stall === 1'b1) n++;
            sync;
        end
        exp_va = miss_q.pop_front();
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL miss_report_timeout va=%h: itlb_ready never rose within 10 cycles", v);
        end else if (n != ML || itlb_miss !== 1'b1 || itlb_stall !== 1'b0 || faulty_va !== exp_va) begin
            fails++;
            $display("FAIL miss_report: walk_stall_cycles=%0d miss=%b stall=%b faulty_va=%h, expected %0d 1 0 %h",
                     n, itlb_miss, itlb_stall, faulty_va, ML, exp_va);
        end
        sync;
        abort = 1'b0;
        #2;
        tests++;
        if (itlb_ready !== 1'b0 || itlb_miss !== 1'b1 || itlb_stall !== 1'b0) begin
            fails++;
            $display("FAIL wait_refill: ready=%b miss=%b stall=%b, expected 0 1 0", itlb_ready, itlb_miss, itlb_stall);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b1; va = 32'h00401A3C; abort = 1'b0;
        tlb_we = 1'b0; tlb_flush = 1'b0; tlb_vpn = '0; tlb_ppn = '0;
        repeat (2) sync;
        #2;
        tests++;
        if ({itlb_stall, itlb_miss, itlb_ready, hit} !== 4'b0000 || faulty_va !== 32'h0 || pa !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: stall=%b miss=%b ready=%b hit=%b faulty_va=%h pa=%h, expected all 0",
                     itlb_stall, itlb_miss, itlb_ready, hit, faulty_va, pa);
        end
        rst_n = 1'b1;
        req   = 1'b0;
        sync;
    endtask

    task automatic test_miss_report;
        miss_report(32'h00401A3C, 1'b0);
    endtask

    task automatic test_refill;
        refill(20'h00401, 20'h12345, 1'b0);
        #2;
        tests++;
        if (itlb_miss !== 1'b0 || faulty_va !== 32'h0 || itlb_stall !== 1'b0) begin
            fails++;
            $display("FAIL refill_exit: miss=%b faulty_va=%h stall=%b, expected 0 0 0", itlb_miss, faulty_va, itlb_stall);
        end
        lookup(32'h00401A3C, 1'b1, 32'h12345A3C);
    endtask

    task automatic test_replacement;
        tlb_flush = 1'b1;
        sync;
        tlb_flush = 1'b0;
        for (int i = 1; i <= 5; i++) refill(20'(i), 20'(256 + i), 1'b0);
        lookup({20'd1, 12'h123}, 1'b0, 32'h0);
        for (int i = 2; i <= 5; i++) lookup({20'(i), 12'h123}, 1'b1, {20'(256 + i), 12'h123});
    endtask

    task automatic test_overwrite;
        refill(20'd3, 20'h00077, 1'b0);
        lookup({20'd3, 12'h123}, 1'b1, 32'h00077123);
        lookup({20'd2, 12'h123}, 1'b1, {20'h00102, 12'h123});
        // Next new VPN must land on the slot the pointer held before the in-place overwrite.
        refill(20'd7, 20'h00107, 1'b0);
        lookup({20'd2, 12'h123}, 1'b0, 32'h0);
        lookup({20'd3, 12'h456}, 1'b1, 32'h00077456);
        lookup({20'd4, 12'h123}, 1'b1, {20'h00104, 12'h123});
        lookup({20'd5, 12'h123}, 1'b1, {20'h00105, 12'h123});
        lookup({20'd7, 12'hFFF}, 1'b1, {20'h00107, 12'hFFF});
    endtask

    task automatic test_abort;
        req = 1'b1; va = 32'h00ABC010; abort = 1'b0;
        #2;
        tests++;
        if (itlb_stall !== 1'b1 || hit !== 1'b0) begin
            fails++;
            $display("FAIL abort_detect: stall=%b hit=%b, expected 1 0", itlb_stall, hit);
        end
        sync;
        req = 1'b0;
        #2;
        tests++;
        if (itlb_stall !== 1'b1 || itlb_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_walk1: stall=%b ready=%b, expected 1 0", itlb_stall, itlb_ready);
        end
        sync;
        abort = 1'b1;
        #2;
        tests++;
        if (itlb_stall !== 1'b1) begin
            fails++;
            $display("FAIL abort_walk2: stall=%b, expected 1", itlb_stall);
        end
        sync;
        abort = 1'b0;
        #2;
        tests++;
        if (itlb_stall !== 1'b0 || itlb_miss !== 1'b0 || itlb_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: stall=%b miss=%b ready=%b, expected 0 0 0", itlb_stall, itlb_miss, itlb_ready);
        end
        for (int c = 0; c < 4; c++) begin
            sync;
            #2;
            tests++;
            if (itlb_ready !== 1'b0 || itlb_miss !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_report cycle %0d: ready=%b miss=%b, expected 0 0", c, itlb_ready, itlb_miss);
            end
        end
        miss_report(32'h00ABD020, 1'b1);
        req = 1'b1;
        va  = 32'h00ABE030;
        #2;
        tests++;
        if (itlb_stall !== 1'b0 || hit !== 1'b0) begin
            fails++;
            $display("FAIL wait_refill_miss: stall=%b hit=%b, expected 0 0", itlb_stall, hit);
        end
        sync;
        sync;
        #2;
        tests++;
        if (itlb_ready !== 1'b0 || itlb_miss !== 1'b1 || itlb_stall !== 1'b0 || faulty_va !== 32'h00ABD020) begin
            fails++;
            $display("FAIL wait_refill_no_walk: ready=%b miss=%b stall=%b faulty_va=%h, expected 0 1 0 00abd020",
                     itlb_ready, itlb_miss, itlb_stall, faulty_va);
        end
        req = 1'b0;
        refill(20'h00ABD, 20'h00200, 1'b0);
        #2;
        tests++;
        if (itlb_miss !== 1'b0) begin
            fails++;
            $display("FAIL abort_refill_exit: miss=%b, expected 0", itlb_miss);
        end
    endtask

    task automatic test_reset_flush;
        req = 1'b1; va = 32'h00CC0000;
        #2;
        sync;
        req = 1'b0;
        #2;
        tests++;
        if (itlb_stall !== 1'b1) begin
            fails++;
            $display("FAIL rst_walk: stall=%b, expected 1", itlb_stall);
        end
        rst_n = 1'b0;
        req   = 1'b1;
        va    = {20'd5, 12'h123};
        #1;
        tests++;
        if ({itlb_stall, itlb_miss, itlb_ready, hit} !== 4'b0000 || faulty_va !== 32'h0 || pa !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_walk: stall=%b miss=%b ready=%b hit=%b faulty_va=%h pa=%h, expected all 0",
                     itlb_stall, itlb_miss, itlb_ready, hit, faulty_va, pa);
        end
        sync;
        rst_n = 1'b1;
        req   = 1'b0;
        lookup({20'd5, 12'h123}, 1'b0, 32'h0);
        refill(20'h00044, 20'h00144, 1'b0);
        lookup(32'h00044ABC, 1'b1, 32'h00144ABC);
        miss_report(32'h00066010, 1'b0);
        refill(20'h00066, 20'h00166, 1'b1);
        #2;
        tests++;
        if (itlb_miss !== 1'b0 || faulty_va !== 32'h0) begin
            fails++;
            $display("FAIL flush_we_exit: miss=%b faulty_va=%h, expected 0 0", itlb_miss, faulty_va);
        end
        lookup(32'h00044ABC, 1'b0, 32'h0);
        lookup(32'h00066010, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_miss_report;
        test_refill;
        test_replacement;
        test_overwrite;
        test_abort;
        test_reset_flush;
        tests++;
        if (look_q.size() != 0 || miss_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: look_q=%0d miss_q=%0d left, expected 0 0", look_q.size(), miss_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
